// File: rtl/sequenceur_chute.sv
// Game-flow sequencer for the three-column brick stack: spawn, gravity fall, landing, game over.
// Optional macro TROIS_CLEAR_EN adds a CLEAR state that removes a full bottom row after each landing.
module sequenceur_chute #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter logic [2:0]  ROW_TOP  = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       fastDrop,
    input  logic [1:0] col,
    output logic [2:0] row,
    output logic [2:0] hauteurGauche,
    output logic [2:0] hauteurCentre,
    output logic [2:0] hauteurDroite,
    output logic       landed,
    output logic       gameOver,
    output logic [7:0] score,
    output logic [2:0] etat
);

    localparam int unsigned      CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

`ifdef TROIS_CLEAR_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        FALL  = 3'd2,
        LAND  = 3'd3,
        CLEAR = 3'd4,
        OVER  = 3'd5
    } etat_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        FALL  = 3'd2,
        LAND  = 3'd3,
        OVER  = 3'd5
    } etat_t;
`endif

    etat_t            state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel_col;
    logic [2:0]       h_sel;
    logic             step;

    function automatic logic [2:0] inc_sat(input logic [2:0] h);
        return (h >= ROW_TOP) ? ROW_TOP : h + 3'd1;
    endfunction

    // Column 3 does not exist on the board; it aliases to the centre column.
    always_comb begin
        sel_col = (col == 2'd3) ? 2'd1 : col;
        case (sel_col)
            2'd0:    h_sel = hauteurGauche;
            2'd2:    h_sel = hauteurDroite;
            default: h_sel = hauteurCentre;
        endcase
        step = fastDrop || (cnt == TICK_LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = SPAWN;
            SPAWN: state_next = (h_sel >= ROW_TOP) ? OVER : FALL;
            FALL:  if (step && (row <= h_sel)) state_next = LAND;
`ifdef TROIS_CLEAR_EN
            LAND:  state_next = CLEAR;
            CLEAR: state_next = SPAWN;
`else
            LAND:  state_next = SPAWN;
`endif
            OVER:  if (start) state_next = SPAWN;
            default: state_next = IDLE;
        endcase
    end

    // Heights and score move on the landing edge so they are already visible during LAND.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            row           <= ROW_TOP;
            hauteurGauche <= 3'd0;
            hauteurCentre <= 3'd0;
            hauteurDroite <= 3'd0;
            landed        <= 1'b0;
            gameOver      <= 1'b0;
            score         <= 8'd0;
            cnt           <= '0;
        end else begin
            state    <= state_next;
            landed   <= (state_next == LAND);
            gameOver <= (state_next == OVER);
            case (state)
                SPAWN: begin
                    row <= ROW_TOP;
                    cnt <= '0;
                end
                FALL: begin
                    if (step) begin
                        cnt <= '0;
                        if (row <= h_sel) begin
                            score <= score + 8'd1;
                            case (sel_col)
                                2'd0:    hauteurGauche <= inc_sat(hauteurGauche);
                                2'd2:    hauteurDroite <= inc_sat(hauteurDroite);
                                default: hauteurCentre <= inc_sat(hauteurCentre);
                            endcase
                        end else begin
                            row <= row - 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef TROIS_CLEAR_EN
                CLEAR: begin
                    if ((hauteurGauche != 3'd0) && (hauteurCentre != 3'd0) &&
                        (hauteurDroite != 3'd0)) begin
                        hauteurGauche <= hauteurGauche - 3'd1;
                        hauteurCentre <= hauteurCentre - 3'd1;
                        hauteurDroite <= hauteurDroite - 3'd1;
                        score         <= score + 8'd1;
                    end
                end
`endif
                OVER: begin
                    if (start) begin
                        hauteurGauche <= 3'd0;
                        hauteurCentre <= 3'd0;
                        hauteurDroite <= 3'd0;
                        score         <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign etat = state;

endmodule

// File: doc/sequenceur_chute.md
Name: sequenceur_chute

Overview:
Game-flow sequencer for the three-column brick stack. Spawns each brick at the top row, drops it one row per gravity tick (or per fast-drop pulse), detects landing on the current column's stack and updates the three column heights. Feeds `row` and `hauteurGauche/Centre/Droite` to the column controller and receives its `col` in return. Detects game over.

Parameters:
TICK_DIV, 25000000, clock cycles per gravity step (use 4 in simulation); minimum 2.
ROW_TOP, 7, spawn row and maximum stack height (3-bit domain).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse (already debounced); starts or restarts a game
fastDrop  input  1  one-cycle pulse; forces an immediate gravity step
col  input  2  current brick column from the controller (0=gauche, 1=centre, 2=droite)
row  output  3  current brick row (bottom of brick)
hauteurGauche  output  3  stack height, column 0
hauteurCentre  output  3  stack height, column 1
hauteurDroite  output  3  stack height, column 2
landed  output  1  one-cycle pulse when a brick lands
gameOver  output  1  high while in OVER
score  output  8  count of landed bricks (wraps at 255)
etat  output  3  current state encoding, for debug only

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. All outputs are registered.
- Reset values: etat=IDLE, row=ROW_TOP, all heights=0, landed=0, gameOver=0, score=0, tick counter=0.
- States: IDLE, SPAWN, FALL, LAND, (CLEAR, feature only), OVER.
- IDLE: waits for `start`, then goes to SPAWN. Other inputs are ignored.
- SPAWN (1 cycle):
  - row <= ROW_TOP; tick counter <= 0.
  - If the height of column `col` >= ROW_TOP, go to OVER; else go to FALL.
- FALL:
  - Tick counter increments each cycle. A step fires when counter == TICK_DIV-1 (counter then <= 0) or when `fastDrop`=1 (counter <= 0).
  - Tick and fastDrop in the same cycle produce exactly one step.
  - On a step, compare against the height h of column `col`, using the pre-edge `col` value:
    - row <= h: go to LAND; row is unchanged.
    - otherwise: row <= row-1.
  - row never underflows: row=0 always satisfies row <= h.
- LAND (1 cycle):
  - Height of `col` <= min(h+1, ROW_TOP).
  - landed=1 for this cycle only; score <= score+1.
  - Next state: CLEAR if the feature is enabled, else SPAWN.
- OVER:
  - gameOver=1; heights and row are frozen; fastDrop is ignored.
  - `start` clears all heights and score, drops gameOver, and goes to SPAWN.
- `start` outside IDLE/OVER is ignored.
- `col` values of 3 are treated as 1 (centre) for height selection.
- Latency: start at cycle n → SPAWN at n+1 → FALL with row=ROW_TOP at n+2. First gravity step occurs TICK_DIV cycles after entering FALL. Landing to next spawn is 2 cycles (3 with CLEAR).
- Reset mid-operation: takes effect on the next edge from any state; an in-flight brick is discarded and no landed pulse is generated.

Optional Feature:
TROIS_CLEAR_EN
- Defined: adds a one-cycle CLEAR state after LAND.
  - If all three heights >= 1: every height is decremented by 1 (a full bottom row is cleared) and score gets an extra +1.
  - Else: no change.
  - CLEAR then goes to SPAWN.
- Undefined: the CLEAR state and its logic are absent; LAND goes straight to SPAWN and heights only increase.

Test Plan:
1. TICK_DIV=4, reset, start, col=1 → row=7 two cycles after start. Row then decrements every 4 cycles down to 0; the next step gives landed pulse, hauteurCentre=1, score=1, and row=7 again two cycles later.
2. In FALL, fastDrop every cycle from row=7 with heights 0 → row decrements once per cycle. A tick coinciding with fastDrop gives a single decrement, never 2.
3. Land 7 bricks in col=1 → hauteurCentre=7. Next SPAWN goes to OVER with gameOver=1. fastDrop is ignored; start → heights 0, score 0, gameOver=0, row=7.
4. Feature on: hauteurGauche=1, hauteurCentre=1, land in col=2 at row 0 → hauteurDroite=1 in LAND, all three heights 0 after CLEAR, score +2. Feature off, same stimulus: heights 1/1/1, score +1.
5. Reset asserted in FALL at row=4 with hauteurCentre=3 → next cycle etat=IDLE, row=7, heights 0, score 0, no landed pulse.
6. hauteurDroite=2, brick at row=3 in col=2, step → row=2; next step → LAND, hauteurDroite=3.
